// File: rtl/rtl_pkg.sv
// Shared package for rotating-pointer arbitration blocks.
//   state_e   : two-state handshake encoding (ST_IDLE / ST_HOLD)
//   wrap_inc  : modulo-m increment for rotating pointers whose range
//               need not be a power of two
package rtl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Wraps m-1 -> 0 explicitly so that a pointer of N bits never lands on
    // an index in the unused range m..2**N-1.
    function automatic int wrap_inc(input int idx, input int m);
        return (idx >= m - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req, searching upward from
// index 'start' and wrapping at M-1 back to 0.
//   req      [M-1:0] in   request vector
//   start    [N-1:0] in   first index to examine (must be < M)
//   pick_idx [N-1:0] out  winning index (0 when pick_vld=0)
//   pick_vld         out  at least one request bit is set
module rr_pick #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic [M-1:0] req,
    input  logic [N-1:0] start,
    output logic [N-1:0] pick_idx,
    output logic         pick_vld
);

    logic [M-1:0] rot;   // req rotated so that 'start' sits at bit 0
    logic [N-1:0] off;   // offset of the winner from 'start'
    logic [N:0]   sum;   // one extra bit so start+off cannot overflow

    // NOTE: every variable written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch.
    always_comb begin
        // Rotating within M bits (not 2**N) via a doubled vector keeps the
        // wrap point at M-1 for non-power-of-two requester counts.
        rot      = M'({req, req} >> start);

        // Fixed-priority encode, lowest bit wins: scanning down lets the
        // last hit be the lowest set bit.
        off      = '0;
        pick_vld = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off      = N'(i);
                pick_vld = 1'b1;
            end
        end

        // Un-rotate: start+off modulo M. Both operands are < M, so a single
        // conditional subtract is enough.
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (N + 1)'(M)) begin
            sum = sum - (N + 1)'(M);
        end
        pick_idx = sum[N-1:0];
    end

endmodule

// File: rtl/rr_grant_enc.sv
// Round-robin arbiter producing a registered binary grant index with a
// valid/ready handshake; gnt_idx feeds a binary-to-one-hot decoder downstream.
//   clk              in   rising-edge clock
//   rst              in   synchronous, active-high reset
//   req     [M-1:0]  in   request vector
//   gnt_vld          out  gnt_idx holds a valid grant
//   gnt_idx [N-1:0]  out  index of the granted requester (always < M)
//   gnt_rdy          in   consumer accepts the grant when gnt_vld=1
// The grant is frozen until accepted; priority then rotates past the accepted
// requester. All outputs come straight from flops.
module rr_grant_enc
    import rtl_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] req,
    output logic         gnt_vld,
    output logic [N-1:0] gnt_idx,
    input  logic         gnt_rdy
);

    generate
        if (M < 2 || M > (1 << N)) begin : g_bad_m
            $error("rr_grant_enc: M must satisfy 2 <= M <= 2**N");
        end
    endgenerate

    // Reset puts the pointer on the last requester so requester 0 is first.
    localparam logic [N-1:0] PTR_RST = N'(M - 1);

    state_e       state_q,   state_d;
    logic [N-1:0] ptr_q,     ptr_d;      // last accepted grant
    logic [N-1:0] gnt_idx_q, gnt_idx_d;
    logic         gnt_vld_q, gnt_vld_d;

    logic         accept;
    logic [N-1:0] pick_start;
    logic [N-1:0] pick_idx;
    logic         pick_vld;

    // On acceptance the pointer becomes gnt_idx this very cycle, so the
    // search must already start past gnt_idx to allow back-to-back grants.
    assign accept     = (state_q == ST_HOLD) && gnt_rdy;
    assign pick_start = accept ? N'(wrap_inc(int'(gnt_idx_q), M))
                               : N'(wrap_inc(int'(ptr_q), M));

    rr_pick #(
        .N (N),
        .M (M)
    ) u_pick (
        .req      (req),
        .start    (pick_start),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_idx_d = pick_idx;
                    gnt_vld_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Without gnt_rdy nothing moves, even if req drops.
                if (accept) begin
                    ptr_d = gnt_idx_q;
                    if (pick_vld) begin
                        gnt_idx_d = pick_idx;
                    end else begin
                        gnt_vld_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PTR_RST;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt_vld = gnt_vld_q;
    assign gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_rr_grant_enc.sv
// Self-checking bench for rr_grant_enc: one instance with N=2/M=4 and one with
// N=3/M=5. A behavioural model pushes expected outputs to a scoreboard queue
// when inputs are driven; entries are popped and compared after the edge.
module tb_rr_grant_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=2, M=4
    logic       rst_a, rdy_a, vld_a;
    logic [3:0] req_a;
    logic [1:0] idx_a;
    // Instance B: N=3, M=5
    logic       rst_b, rdy_b, vld_b;
    logic [4:0] req_b;
    logic [2:0] idx_b;

    rr_grant_enc #(.N(2), .M(4)) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .req     (req_a),
        .gnt_vld (vld_a),
        .gnt_idx (idx_a),
        .gnt_rdy (rdy_a)
    );

    rr_grant_enc #(.N(3), .M(5)) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .req     (req_b),
        .gnt_vld (vld_b),
        .gnt_idx (idx_b),
        .gnt_rdy (rdy_b)
    );

    typedef struct {
        int   dut;
        logic vld;
        int   idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state per instance
    int   m_ptr_a = 0, m_idx_a = 0;
    logic m_vld_a = 1'b0;
    int   m_ptr_b = 0, m_idx_b = 0;
    logic m_vld_b = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Linear search upward from 'start', wrapping at m.
    function automatic int find(input int m, input logic [7:0] r, input int start);
        for (int k = 0; k < m; k++) begin
            int j;
            j = (start + k) % m;
            if (r[j[2:0]]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int m, input logic [7:0] r, input logic rdy,
                              input logic rst_i, inout int ptr, inout logic vld,
                              inout int idx);
        int p;
        if (rst_i) begin
            vld = 1'b0;
            idx = 0;
            ptr = m - 1;
        end else if (!vld) begin
            p = find(m, r, (ptr + 1) % m);
            if (p >= 0) begin
                idx = p;
                vld = 1'b1;
            end
        end else if (rdy) begin
            ptr = idx;
            p   = find(m, r, (idx + 1) % m);
            if (p >= 0) idx = p;
            else        vld = 1'b0;
        end
    endtask

    // One clock: model both instances from the inputs now driven, push the
    // expectations, then compare once the DUTs have taken the edge.
    task automatic tick();
        exp_t e;
        model_step(4, 8'(req_a), rdy_a, rst_a, m_ptr_a, m_vld_a, m_idx_a);
        e.dut = 0; e.vld = m_vld_a; e.idx = m_idx_a;
        sb.push_back(e);
        model_step(5, 8'(req_b), rdy_b, rst_b, m_ptr_b, m_vld_b, m_idx_b);
        e.dut = 1; e.vld = m_vld_b; e.idx = m_idx_b;
        sb.push_back(e);

        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                check("a_vld", int'(vld_a), int'(e.vld));
                check("a_idx", int'(idx_a), e.idx);
            end else begin
                check("b_vld", int'(vld_b), int'(e.vld));
                check("b_idx", int'(idx_b), e.idx);
            end
        end
        check("b_idx_range", int'(idx_b < 3'd5), 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_a = 1'b1; req_a = '0; rdy_a = 1'b0;
        rst_b = 1'b1; req_b = '0; rdy_b = 1'b0;
        #2;

        // 1: reset, then idle
        ticks(2);
        check("rst_vld", int'(vld_a), 0);
        check("rst_idx", int'(idx_a), 0);
        rst_a = 1'b0; rst_b = 1'b0;
        ticks(5);
        check("idle_vld", int'(vld_a), 0);

        // 2: alternating requesters 1 and 3 at full throughput
        req_a = 4'b1010; rdy_a = 1'b1;
        tick(); check("alt_g0", int'(idx_a), 1);
        tick(); check("alt_g1", int'(idx_a), 3);
        tick(); check("alt_g2", int'(idx_a), 1);
        tick(); check("alt_g3", int'(idx_a), 3);
        check("alt_vld", int'(vld_a), 1);
        req_a = '0;
        ticks(2);
        check("alt_drain", int'(vld_a), 0);

        // 3: hold under backpressure, then rotate 1,2,3,0
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        req_a = 4'b1111; rdy_a = 1'b0;
        ticks(4);
        check("bp_hold", int'(idx_a), 0);
        rdy_a = 1'b1;
        tick(); check("rot_1", int'(idx_a), 1);
        tick(); check("rot_2", int'(idx_a), 2);
        tick(); check("rot_3", int'(idx_a), 3);
        tick(); check("rot_0", int'(idx_a), 0);

        // 4: pending grant 2 survives req dropping; accept -> idle
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        req_a = 4'b0100; rdy_a = 1'b0;
        tick();
        req_a = '0;
        ticks(3);
        check("keep_idx", int'(idx_a), 2);
        check("keep_vld", int'(vld_a), 1);
        rdy_a = 1'b1;
        tick();
        check("drop_vld", int'(vld_a), 0);

        // 5: M=5 wrap 4 -> 0
        req_b = 5'b10000; rdy_b = 1'b1;
        tick(); check("m5_g4", int'(idx_b), 4);
        req_b = 5'b10001;
        tick(); check("m5_g0", int'(idx_b), 0);
        req_b = '0;
        ticks(2);

        // 6: reset mid-hold drops the grant; requester 0 first afterwards
        rdy_a = 1'b0; req_a = 4'b1000;
        ticks(2);
        check("pre_rst_idx", int'(idx_a), 3);
        req_a = 4'b1111; rst_a = 1'b1;
        tick();
        check("midrst_vld", int'(vld_a), 0);
        check("midrst_idx", int'(idx_a), 0);
        rst_a = 1'b0;
        tick();
        check("post_rst_g", int'(idx_a), 0);

        // Random traffic on both instances with occasional resets
        for (int i = 0; i < 400; i++) begin
            req_a = 4'($urandom_range(0, 15));
            req_b = 5'($urandom_range(0, 31));
            rdy_a = 1'($urandom_range(0, 1));
            rdy_b = 1'($urandom_range(0, 1));
            rst_a = ($urandom_range(0, 40) == 0);
            rst_b = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
